// File: rtl/alu_result_uart_tx_pkg.sv
// Shared definitions for the ALU result UART return path: byte-level FSM
// states, two-byte sequencer states, flags-byte layout and default baud divisor.
package alu_result_uart_tx_pkg;

  // 100 MHz system clock / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  // Bit positions inside the flags byte (byte 1 of every report)
  localparam int FLAG_CARRY = 0;
  localparam int FLAG_ZERO  = 1;

  // One 8N1 byte: idle line, start bit, eight data bits, stop bit
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Which byte of the two-byte report is on the line
  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_BYTE0 = 2'd1,
    SEQ_BYTE1 = 2'd2
  } seq_state_e;

  // Pack the ALU flags into the transmitted flags byte; upper bits are zero
  function automatic logic [7:0] make_flags(input logic zero, input logic carry);
    logic [7:0] f;
    f = 8'h00;
    f[FLAG_ZERO]  = zero;
    f[FLAG_CARRY] = carry;
    return f;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single 8N1 byte transmitter: baud counter, bit counter and shifter.
// i_start is taken when idle, or in the last cycle of the stop bit so that a
// following byte starts with no idle gap. o_byte_done marks that last cycle.
module uart_tx_byte
  import alu_result_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int NB_BAUD_CNT  = 10
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  output logic       o_tx,
  output logic       o_byte_done
);

  localparam logic [NB_BAUD_CNT-1:0] CNT_LAST = NB_BAUD_CNT'(CLKS_PER_BIT - 1);

  tx_state_e              state_q, state_n;
  logic [NB_BAUD_CNT-1:0] cnt_q, cnt_n;
  logic [2:0]             bit_q, bit_n;
  logic [7:0]             sh_q, sh_n;
  logic                   tx_q, tx_n;
  logic                   wrap;

  assign wrap        = (cnt_q == CNT_LAST);
  assign o_byte_done = (state_q == TX_STOP) && wrap;
  assign o_tx        = tx_q;

  // State, counters, shifter and the registered line
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      bit_q   <= bit_n;
      sh_q    <= sh_n;
      tx_q    <= tx_n;
    end
  end

  // Next-state logic; the line value is decided one cycle ahead so o_tx is a flop
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    bit_n   = bit_q;
    sh_n    = sh_q;
    tx_n    = tx_q;
    case (state_q)
      TX_IDLE: begin
        cnt_n = '0;
        tx_n  = 1'b1;
        if (i_start) begin
          state_n = TX_START;
          bit_n   = '0;
          sh_n    = i_byte;
          tx_n    = 1'b0;
        end
      end
      TX_START: begin
        if (wrap) begin
          state_n = TX_DATA;
          cnt_n   = '0;
          tx_n    = sh_q[0];
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (wrap) begin
          cnt_n = '0;
          if (bit_q == 3'd7) begin
            state_n = TX_STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n = bit_q + 3'd1;
            sh_n  = {1'b0, sh_q[7:1]};
            tx_n  = sh_q[1];
          end
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (wrap) begin
          cnt_n = '0;
          if (i_start) begin
            state_n = TX_START;
            bit_n   = '0;
            sh_n    = i_byte;
            tx_n    = 1'b0;
          end else begin
            state_n = TX_IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      default: begin
        state_n = TX_IDLE;
        cnt_n   = '0;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_result_uart_tx.sv
// ALU result return path: on each accepted request, sends the result byte
// followed by the flags byte ({6'b0, zero, carry}) as two back-to-back 8N1 frames.
// Handshake: a request is accepted on a rising edge where i_valid && o_ready;
// o_ready is high only while idle, requests seen while busy are ignored (no
// queueing), so a requester holds i_valid until it observes o_ready.
module alu_result_uart_tx
  import alu_result_uart_tx_pkg::*;
#(
  parameter int NB_DATA      = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int NB_BAUD_CNT  = 10
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_result,
  input  logic               i_zero,
  input  logic               i_carry,
  input  logic               i_valid,
  output logic               o_ready,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_tx
);

  seq_state_e         seq_q, seq_n;
  logic [NB_DATA-1:0] result_q;
  logic [7:0]         flags_q;
  logic               done_q, done_n;
  logic               accept;
  logic               tx_start;
  logic [7:0]         tx_byte;
  logic               byte_done;

  assign accept  = (seq_q == SEQ_IDLE) && i_valid;
  assign o_ready = (seq_q == SEQ_IDLE);
  assign o_busy  = ~o_ready;
  assign o_done  = done_q;

  // Sequencer state and the end-of-report pulse
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      seq_q  <= SEQ_IDLE;
      done_q <= 1'b0;
    end else begin
      seq_q  <= seq_n;
      done_q <= done_n;
    end
  end

  // Snapshot of the ALU outputs; later input changes cannot reach the line
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      result_q <= '0;
      flags_q  <= '0;
    end else if (accept) begin
      result_q <= i_result;
      flags_q  <= make_flags(i_zero, i_carry);
    end
  end

  // Two-byte sequencing: byte 0 starts on accept (straight from the inputs,
  // as the snapshot loads on the same edge), byte 1 chains off byte 0's stop bit
  always_comb begin
    seq_n    = seq_q;
    done_n   = 1'b0;
    tx_start = 1'b0;
    tx_byte  = result_q;
    case (seq_q)
      SEQ_IDLE: begin
        if (i_valid) begin
          seq_n    = SEQ_BYTE0;
          tx_start = 1'b1;
          tx_byte  = i_result;
        end
      end
      SEQ_BYTE0: begin
        if (byte_done) begin
          seq_n    = SEQ_BYTE1;
          tx_start = 1'b1;
          tx_byte  = flags_q;
        end
      end
      SEQ_BYTE1: begin
        if (byte_done) begin
          seq_n  = SEQ_IDLE;
          done_n = 1'b1;
        end
      end
      default: seq_n = SEQ_IDLE;
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .NB_BAUD_CNT (NB_BAUD_CNT)
  ) u_tx_byte (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_start    (tx_start),
    .i_byte     (tx_byte),
    .o_tx       (o_tx),
    .o_byte_done(byte_done)
  );

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Bench for alu_result_uart_tx with a fast baud divisor. Stimulus pushes the
// expected bytes and o_done times; independent monitors decode the line and
// watch o_done and pop the queues.
module tb_alu_result_uart_tx;

  localparam int C  = 4;
  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [NB-1:0] i_result = '0;
  logic          i_zero = 1'b0;
  logic          i_carry = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready, o_busy, o_done, o_tx;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int rst_gen = 0;

  logic [7:0] exp_q[$];
  int         done_q[$];

  alu_result_uart_tx #(
    .NB_DATA(NB), .CLKS_PER_BIT(C), .NB_BAUD_CNT(10)
  ) dut (
    .clk(clk), .i_rst(i_rst), .i_result(i_result), .i_zero(i_zero),
    .i_carry(i_carry), .i_valid(i_valid), .o_ready(o_ready),
    .o_busy(o_busy), .o_done(o_done), .o_tx(o_tx)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // A request produces the result byte, then {6'b0, zero, carry}, and o_done
  // appears 20 bit times after the accept edge.
  task automatic expect_report(input logic [7:0] res, input logic z, input logic c, input int acc_cyc);
    exp_q.push_back(res);
    exp_q.push_back({6'b0, z, c});
    done_q.push_back(acc_cyc + 20 * C);
  endtask

  // ---------------- driver tasks ----------------
  // Raise a request and hold it until accepted (bounded)
  task automatic send(input logic [7:0] res, input logic z, input logic c);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    i_result = res; i_zero = z; i_carry = c; i_valid = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (o_ready) begin ok = 1; break; end
    end
    if (ok) begin
      expect_report(res, z, c, cyc + 1);
      @(posedge clk); #1;
    end else begin
      check("send_ready_timeout", 0, 1);
    end
    i_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait until everything expected has been observed (bounded)
  task automatic drain();
    bit ok;
    ok = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && done_q.size() == 0 && o_ready) begin ok = 1; break; end
    end
    check("drain_timeout", {31'b0, ok}, 1);
    #1;
  endtask

  // ---------------- monitors ----------------
  // UART line decoder: find start bit, sample mid-bit, compare against queue
  initial begin : rx_mon
    logic       s0, s1;
    logic [7:0] b;
    int         g;
    forever begin
      @(negedge clk);
      if (!i_rst && o_tx === 1'b0) begin
        g = rst_gen;
        repeat (C / 2) @(negedge clk);
        s0 = o_tx;
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk);
          b[i] = o_tx;
        end
        repeat (C) @(negedge clk);
        s1 = o_tx;
        if (g == rst_gen) begin
          if (exp_q.size() == 0) begin
            check("rx_unexpected_byte", {22'b0, s0, b, s1}, 32'h3FF);
          end else begin
            check("rx_frame", {22'b0, s0, b, s1}, {22'b0, 1'b0, exp_q.pop_front(), 1'b1});
          end
        end
      end
    end
  end

  // o_done timing and busy/ready consistency
  initial begin : done_mon
    forever begin
      @(negedge clk);
      if (!i_rst) begin
        check("busy_is_not_ready", {31'b0, o_busy}, {31'b0, ~o_ready});
        if (o_done === 1'b1) begin
          if (done_q.size() == 0) check("done_unexpected", cyc, 0);
          else check("done_cycle", cyc, done_q.pop_front());
          check("ready_with_done", {31'b0, o_ready}, 1);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int acc;
    bit ok;
    logic [7:0] r;
    logic z, c;

    // reset then idle
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      check("idle_outputs", {28'b0, o_tx, o_ready, o_busy, o_done}, 32'b1100);
    end

    // single send of A5 with carry
    send(8'hA5, 1'b0, 1'b1);
    drain();

    // snapshot: inputs change right after accept
    send(8'h3C, 1'b0, 1'b0);
    i_result = 8'hFF; i_zero = 1'b1; i_carry = 1'b1;
    drain();

    // busy drop: a request raised mid-frame for two cycles is ignored
    send(8'hA0, 1'b1, 1'b1);
    idle_cycles(8);
    i_result = 8'h11; i_zero = 1'b0; i_carry = 1'b0; i_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("ready_low_while_busy", {31'b0, o_ready}, 0);
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    drain();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("line_idle_after_done", {30'b0, o_tx, o_ready}, 32'b11);
    end

    // back-to-back: held request accepted in the o_done cycle
    @(posedge clk); #1;
    i_result = 8'h00; i_zero = 1'b1; i_carry = 1'b0; i_valid = 1'b1;
    @(negedge clk);
    check("b2b_first_ready", {31'b0, o_ready}, 1);
    expect_report(8'h00, 1'b1, 1'b0, cyc + 1);
    @(posedge clk);
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (o_ready) begin ok = 1; break; end
    end
    check("b2b_ready_seen", {31'b0, ok}, 1);
    if (ok) begin
      check("b2b_accept_on_done", {31'b0, o_done}, 1);
      expect_report(8'h00, 1'b1, 1'b0, cyc + 1);
      @(posedge clk);
    end
    #1 i_valid = 1'b0;
    drain();

    // reset in the middle of byte 0 data bits
    send(8'hC3, 1'b1, 1'b0);
    idle_cycles(13);
    i_rst = 1'b1;
    rst_gen++;
    exp_q.delete();
    done_q.delete();
    #1;
    check("rst_immediate", {29'b0, o_tx, o_ready, o_done}, 32'b110);
    idle_cycles(2);
    i_rst = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      check("post_rst_idle", {29'b0, o_tx, o_ready, o_done}, 32'b110);
    end
    send(8'h5A, 1'b1, 1'b0);
    drain();

    // randomized requests with random gaps
    for (int n = 0; n < 10; n++) begin
      r = 8'($urandom_range(0, 255));
      z = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      idle_cycles($urandom_range(0, 30));
      send(r, z, c);
      if ($urandom_range(0, 1) == 1) begin
        i_result = 8'($urandom); i_zero = 1'($urandom); i_carry = 1'($urandom);
      end
    end
    drain();

    acc = exp_q.size() + done_q.size();
    check("queues_empty_at_end", acc, 0);
    repeat (10) @(negedge clk);
    check("final_line_idle", {30'b0, o_tx, o_ready}, 32'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // global watchdog
  initial begin : watchdog
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
